// File: rtl/schematic_misterioso.sv
// WIDTH-bit right-shift register with parallel load; q[0] leaves first on do_o.
// Define SCHEMATIC_MISTERIOSO_DO_REG_EN to register do_o (one-cycle lag behind q[0]).
module schematic_misterioso #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             clrn_i,
   input  logic [WIDTH-1:0] d_i,
   input  logic             di_i,
   input  logic             load_i,
   output logic [WIDTH-1:0] q_o,
   output logic             do_o
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] shift_w;

   // Serial input enters at the MSB; every other bit takes its upper neighbour.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
         if (gi == WIDTH - 1) begin : g_top
            assign shift_w[gi] = di_i;
         end else begin : g_mid
            assign shift_w[gi] = q_q[gi+1];
         end
      end
   endgenerate

   always_comb begin
      q_d = shift_w;
      if (load_i) begin
         q_d = d_i;
      end
   end

   always_ff @(posedge clk) begin
      if (clrn_i) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

`ifdef SCHEMATIC_MISTERIOSO_DO_REG_EN
   logic do_q;

   always_ff @(posedge clk) begin
      if (clrn_i) begin
         do_q <= 1'b0;
      end else begin
         do_q <= q_q[0];
      end
   end

   assign do_o = do_q;
`else
   assign do_o = q_q[0];
`endif

endmodule

// File: tb/tb_schematic_misterioso.sv
// Self-checking bench for schematic_misterioso: directed cases plus random traffic
// compared every cycle against an arithmetic shift-register model.
module tb_schematic_misterioso;

   localparam int W = 3;

   logic         clk;
   logic         clrn_i;
   logic [W-1:0] d_i;
   logic         di_i;
   logic         load_i;
   logic [W-1:0] q_o;
   logic         do_o;

   int checks = 0;
   int errors = 0;

   schematic_misterioso #(.WIDTH(W)) dut (
      .clk    (clk),
      .clrn_i (clrn_i),
      .d_i    (d_i),
      .di_i   (di_i),
      .load_i (load_i),
      .q_o    (q_o),
      .do_o   (do_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: the register value as a number, updated from the sampled inputs.
   logic [W-1:0] model_q;
   logic         model_do_lag;
   logic         model_valid = 1'b0;
   logic         model_do;

   always @(posedge clk) begin
      if (clrn_i) begin
         model_q      <= '0;
         model_do_lag <= 1'b0;
         model_valid  <= 1'b1;
      end else begin
         if (load_i) model_q <= d_i;
         else        model_q <= (model_q >> 1) | (W'(di_i) << (W - 1));
         model_do_lag <= model_q[0];
      end
   end

`ifdef SCHEMATIC_MISTERIOSO_DO_REG_EN
   assign model_do = model_do_lag;
`else
   assign model_do = model_q[0];
`endif

   always @(negedge clk) begin
      if (model_valid) begin
         checks++;
         if (q_o !== model_q || do_o !== model_do) begin
            errors++;
            $display("FAIL model_cmp t=%0t q=%b do=%b expected q=%b do=%b",
                     $time, q_o, do_o, model_q, model_do);
         end
      end
   end

   task automatic check_lit(input string name, input logic [W-1:0] exp_q, input logic exp_do);
      checks++;
      if (q_o !== exp_q || do_o !== exp_do) begin
         errors++;
         $display("FAIL %s q=%b do=%b expected q=%b do=%b", name, q_o, do_o, exp_q, exp_do);
      end else begin
         $display("ok   %s q=%b do=%b", name, q_o, do_o);
      end
   endtask

   // Drive inputs, let one rising edge sample them, return just after the next falling edge.
   task automatic cyc(input logic c, input logic l, input logic [W-1:0] dd, input logic ddi);
      clrn_i = c;
      load_i = l;
      d_i    = dd;
      di_i   = ddi;
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   initial begin
      clrn_i = 1'b0;
      load_i = 1'b0;
      d_i    = '0;
      di_i   = 1'b0;
      @(negedge clk);
      #1;

      // Reset wins over load.
      cyc(1'b1, 1'b1, 3'b101, 1'b0);
      check_lit("reset_over_load", 3'b000, 1'b0);

      // Parallel load, then d changes between edges without effect.
      cyc(1'b0, 1'b1, 3'b110, 1'b0);
      check_lit("load_110", 3'b110, 1'b0);
      d_i = 3'b001;
      #2;
      check_lit("midcycle_d_toggle", 3'b110, 1'b0);

      // Load then serialise.
`ifdef SCHEMATIC_MISTERIOSO_DO_REG_EN
      cyc(1'b0, 1'b1, 3'b011, 1'b0); check_lit("load_011", 3'b011, 1'b0);
      cyc(1'b0, 1'b0, 3'b000, 1'b1); check_lit("shift1",   3'b101, 1'b1);
      cyc(1'b0, 1'b0, 3'b000, 1'b0); check_lit("shift2",   3'b010, 1'b1);
      cyc(1'b0, 1'b0, 3'b000, 1'b0); check_lit("shift3",   3'b001, 1'b0);
`else
      cyc(1'b0, 1'b1, 3'b011, 1'b0); check_lit("load_011", 3'b011, 1'b1);
      cyc(1'b0, 1'b0, 3'b000, 1'b1); check_lit("shift1",   3'b101, 1'b1);
      cyc(1'b0, 1'b0, 3'b000, 1'b0); check_lit("shift2",   3'b010, 1'b0);
      cyc(1'b0, 1'b0, 3'b000, 1'b0); check_lit("shift3",   3'b001, 1'b1);
`endif

      // Reset in the middle of shifting.
`ifdef SCHEMATIC_MISTERIOSO_DO_REG_EN
      cyc(1'b0, 1'b1, 3'b111, 1'b0); check_lit("load_111",      3'b111, 1'b1);
      cyc(1'b0, 1'b0, 3'b000, 1'b0); check_lit("shift_to_011",  3'b011, 1'b1);
`else
      cyc(1'b0, 1'b1, 3'b111, 1'b0); check_lit("load_111",      3'b111, 1'b1);
      cyc(1'b0, 1'b0, 3'b000, 1'b0); check_lit("shift_to_011",  3'b011, 1'b1);
`endif
      cyc(1'b1, 1'b0, 3'b000, 1'b0); check_lit("reset_midshift", 3'b000, 1'b0);
      cyc(1'b0, 1'b0, 3'b000, 1'b1); check_lit("shift_after_rst", 3'b100, 1'b0);

      // do timing after a load of 001 followed by one shift.
`ifdef SCHEMATIC_MISTERIOSO_DO_REG_EN
      cyc(1'b0, 1'b1, 3'b001, 1'b0); check_lit("do_lag_load", 3'b001, 1'b0);
      cyc(1'b0, 1'b0, 3'b000, 1'b0); check_lit("do_lag_shift", 3'b000, 1'b1);
`else
      cyc(1'b0, 1'b1, 3'b001, 1'b0); check_lit("do_comb_load", 3'b001, 1'b1);
      cyc(1'b0, 1'b0, 3'b000, 1'b0); check_lit("do_comb_shift", 3'b000, 1'b0);
`endif

      // Random traffic; the compare process checks every cycle.
      for (int i = 0; i < 1000; i++) begin
         cyc(($urandom_range(0, 7) == 0), 1'($urandom), W'($urandom), 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
